// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first subtractor computing A - B - BIN over WIDTH clock cycles.
module serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic             IN_CLK,
   input  logic             IN_RST,
   input  logic             IN_START,
   input  logic [WIDTH-1:0] IN_A,
   input  logic [WIDTH-1:0] IN_B,
   input  logic             IN_BIN,
   output logic [WIDTH-1:0] OUT_DIFF,
   output logic             OUT_BOUT,
   output logic             OUT_OVF,
   output logic             OUT_ZERO,
   output logic             OUT_BUSY,
   output logic             OUT_DONE
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_d, r_diff, w_d_next;
   logic [CW-1:0]    r_cnt;
   logic             r_bw, r_bout, r_ovf, r_zero;
   logic             w_a_bit, w_b_bit, w_d_bit, w_bw_next, w_last;
   assign w_a_bit   = r_a[r_cnt];
   assign w_b_bit   = r_b[r_cnt];
   assign w_d_bit   = w_a_bit ^ w_b_bit ^ r_bw;
   assign w_bw_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_bw);
   assign w_last    = r_cnt == CW'(WIDTH - 1);
   // Partial difference with the current bit merged in; on the last bit this is the full result.
   assign w_d_next  = r_d | (WIDTH'(w_d_bit) << r_cnt);
   always_ff @(posedge IN_CLK or posedge IN_RST) begin
      if (IN_RST) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (IN_START ? RUN : IDLE) :
               (r_state == RUN)  ? (w_last ? DONE : RUN)   : IDLE;
   end
   always_comb begin
      OUT_BUSY = r_state == RUN;
      OUT_DONE = r_state == DONE;
   end
   always_ff @(posedge IN_CLK or posedge IN_RST) begin
      if (IN_RST) begin
         r_a    <= '0;
         r_b    <= '0;
         r_d    <= '0;
         r_bw   <= 1'b0;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (r_state == IDLE && IN_START) begin
         r_a   <= IN_A;
         r_b   <= IN_B;
         r_bw  <= IN_BIN;
         r_d   <= '0;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_d   <= w_d_next;
         r_bw  <= w_bw_next;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_diff <= w_d_next;
            r_bout <= w_bw_next;
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_next[WIDTH-1] != r_a[WIDTH-1]);
            r_zero <= ~|w_d_next;
         end
      end
   end
   assign OUT_DIFF = r_diff;
   assign OUT_BOUT = r_bout;
   assign OUT_OVF  = r_ovf;
   assign OUT_ZERO = r_zero;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: checks serial_sub against an arithmetic reference model, directed cases and shuffled exhaustive operands.
module tb_serial_sub;
   localparam int W = 4;
   logic         clk = 0, rst = 0, start = 0, bin = 0;
   logic [W-1:0] a = '0, b = '0;
   logic [W-1:0] o_diff;
   logic         o_bout, o_ovf, o_zero, o_busy, o_done;
   int vectors = 0, errors = 0, cyc = 0;
   int m_t = -1, full = 0, n_done = 0, n_busy = 0, last_rise = -1;
   bit rnd_mode = 0, prev_busy = 0;
   logic [W-1:0] m_a = '0, m_b = '0, e_diff = '0;
   logic         m_bin = 0, e_bout = 0, e_ovf = 0, e_zero = 0;
   int idx [512];

   serial_sub #(.WIDTH(W)) dut (
      .IN_CLK(clk), .IN_RST(rst), .IN_START(start), .IN_A(a), .IN_B(b), .IN_BIN(bin),
      .OUT_DIFF(o_diff), .OUT_BOUT(o_bout), .OUT_OVF(o_ovf), .OUT_ZERO(o_zero),
      .OUT_BUSY(o_busy), .OUT_DONE(o_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: m_t counts edges since the accepting edge (-1 = idle).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = -1; e_diff = '0; e_bout = 0; e_ovf = 0; e_zero = 0;
      end else if (m_t < 0) begin
         if (start) begin m_a = a; m_b = b; m_bin = bin; m_t = 0; end
      end else if (m_t == W) begin
         m_t = -1;
      end else begin
         m_t++;
         if (m_t == W) begin
            full   = int'(m_a) - int'(m_b) - int'(m_bin);
            e_diff = W'(full);
            e_bout = full < 0;
            e_ovf  = (m_a[W-1] != m_b[W-1]) && (e_diff[W-1] != m_a[W-1]);
            e_zero = e_diff == 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(o_busy), 32'(m_t >= 0 && m_t < W));
      chk("done", 32'(o_done), 32'(m_t == W));
      chk("diff", 32'(o_diff), 32'(e_diff));
      chk("bout", 32'(o_bout), 32'(e_bout));
      chk("ovf",  32'(o_ovf),  32'(e_ovf));
      chk("zero", 32'(o_zero), 32'(e_zero));
      if (o_done) n_done++;
      if (o_busy) n_busy++;
      if (rnd_mode && o_busy && !prev_busy) begin
         if (last_rise >= 0) chk("accept_interval", 32'(cyc - last_rise), 32'(W + 2));
         last_rise = cyc;
      end
      prev_busy = o_busy;
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_diff"}, 32'(o_diff), 0);
      chk({tag, "_bout"}, 32'(o_bout), 0);
      chk({tag, "_ovf"},  32'(o_ovf),  0);
      chk({tag, "_zero"}, 32'(o_zero), 0);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
      logic found;
      @(posedge clk); #1 a = ta; b = tb; bin = tbin; start = 1;
      @(posedge clk); #1 start = 0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         found = o_done;
      end
      chk("done_seen", 32'(found), 1);
      chk("lit_diff", 32'(o_diff), 32'(d));
      chk("lit_bout", 32'(o_bout), 32'(bo));
      chk("lit_ovf",  32'(o_ovf),  32'(ov));
      chk("lit_zero", 32'(o_zero), 32'(z));
      chk("model_diff", 32'(e_diff), 32'(d));
      chk("model_bout", 32'(e_bout), 32'(bo));
   endtask

   initial begin
      logic ok;
      int   j, t;
      #1 rst = 1;
      #1 chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 0;
      run_op(7, 3, 0, 4'h4, 0, 0, 0);
      run_op(3, 7, 0, 4'hC, 1, 0, 0);
      run_op(0, 0, 1, 4'hF, 1, 0, 0);
      run_op(8, 1, 0, 4'h7, 0, 1, 0);
      run_op(5, 5, 0, 4'h0, 0, 0, 1);
      // Second request during RUN must be dropped.
      @(posedge clk); #1 n_done = 0; n_busy = 0; a = 9; b = 2; bin = 0; start = 1;
      @(posedge clk); #1 start = 0; a = 1; b = 14; bin = 1;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      repeat (8) @(negedge clk);
      chk("ignored_diff", 32'(o_diff), 7);
      chk("ignored_ndone", 32'(n_done), 1);
      chk("ignored_nbusy", 32'(n_busy), W);
      // Reset in the second RUN cycle aborts the operation.
      @(posedge clk); #1 a = 9; b = 2; bin = 0; start = 1;
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1 rst = 1;
      #1 chk_all_zero("abort");
      n_done = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (6) @(negedge clk);
      chk("abort_ndone", 32'(n_done), 0);
      run_op(6, 1, 0, 4'h5, 0, 0, 0);
      // Shuffled exhaustive operands with START held high.
      for (int i = 0; i < 512; i++) idx[i] = i;
      for (int i = 511; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = idx[i]; idx[i] = idx[j]; idx[j] = t;
      end
      @(posedge clk); #1 rnd_mode = 1; last_rise = -1;
      for (int i = 0; i < 512; i++) begin
         a = W'(idx[i] >> 5); b = W'(idx[i] >> 1); bin = idx[i][0]; start = 1;
         ok = 0;
         for (int k = 0; k < 12 && !ok; k++) begin
            @(posedge clk); #1;
            ok = m_t == 0;
         end
         if (!ok) chk("accept_timeout", 0, 1);
      end
      start = 0;
      repeat (W + 4) @(negedge clk);
      rnd_mode = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
